// File: rtl/uart_sample_framer.sv
// uart_sample_framer: captures one coherent snapshot of four channels every DECIMATE sample_clk
// rising edges and streams it to uart_tx as "CH<n>" MSB LSB per channel.
// Optional build macro UART_SAMPLE_FRAMER_CHECKSUM_EN appends an XOR checksum byte per snapshot.
module uart_sample_framer #(
    parameter int W        = 16,
    parameter int DECIMATE = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_busy,
    output logic         frame_toggle,
    output logic [7:0]   drop_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;

    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    state_t       state_q, state_d;
    logic         sample_clk_q;
    logic         rise;
    logic [7:0]   dec_cnt_q, dec_cnt_d;
    logic [W-1:0] snap_q [4];
    logic [W-1:0] snap_d [4];
    logic [2:0]   ch_q, ch_d;
    logic [2:0]   pos_q, pos_d;
    logic [1:0]   wait_cnt_q, wait_cnt_d;
    logic         tx_start_q, tx_start_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         toggle_q, toggle_d;
    logic [7:0]   drop_q, drop_d;
    logic         capture;
    logic         last_byte;
    logic [7:0]   cur_byte;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    assign rise    = sample_clk & ~sample_clk_q;
    assign capture = (state_q == IDLE) && rise && (dec_cnt_q == DEC_LAST);

    // The checksum occupies channel slot 4, position 0, i.e. byte index 20.
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
    assign last_byte = (ch_q == 3'd4);
`else
    assign last_byte = (ch_q == 3'd3) && (pos_q == 3'd4);
`endif

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign frame_toggle = toggle_q;
    assign drop_cnt     = drop_q;

    always_comb begin
        cur_byte = 8'h00;
        case (pos_q)
            3'd0:    cur_byte = 8'h43;
            3'd1:    cur_byte = 8'h48;
            3'd2:    cur_byte = 8'h30 + {6'b0, ch_q[1:0]};
            3'd3:    cur_byte = snap_q[ch_q[1:0]][W-1:W-8];
            3'd4:    cur_byte = snap_q[ch_q[1:0]][7:0];
            default: cur_byte = 8'h00;
        endcase
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
        if (ch_q == 3'd4) cur_byte = csum_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_clk_q <= 1'b0;
            dec_cnt_q    <= '0;
            snap_q       <= '{default: '0};
            ch_q         <= '0;
            pos_q        <= '0;
            wait_cnt_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            toggle_q     <= 1'b0;
            drop_q       <= '0;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sample_clk_q <= sample_clk;
            dec_cnt_q    <= dec_cnt_d;
            snap_q       <= snap_d;
            ch_q         <= ch_d;
            pos_q        <= pos_d;
            wait_cnt_q   <= wait_cnt_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            toggle_q     <= toggle_d;
            drop_q       <= drop_d;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // WAIT_BUSY gives up after four idle cycles so a fast or missing uart_tx cannot stall us.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (capture) state_d = LOAD;
            LOAD:      if (!tx_busy) state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy || (wait_cnt_q == 2'd3)) state_d = WAIT_IDLE;
            WAIT_IDLE: if (!tx_busy) state_d = last_byte ? IDLE : LOAD;
            default:   state_d = IDLE;
        endcase
    end

    // Edges arriving outside IDLE are only counted as drops; they never touch decimation or snapshot.
    always_comb begin
        dec_cnt_d  = dec_cnt_q;
        snap_d     = snap_q;
        ch_d       = ch_q;
        pos_d      = pos_q;
        wait_cnt_d = wait_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        toggle_d   = toggle_q;
        drop_d     = drop_q;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (rise) begin
            if (state_q == IDLE) dec_cnt_d = capture ? 8'd0 : dec_cnt_q + 8'd1;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_d = '{sample_in0, sample_in1, sample_in2, sample_in3};
                    ch_d   = '0;
                    pos_d  = '0;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            LOAD: begin
                tx_data_d  = cur_byte;
                wait_cnt_d = '0;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
`ifdef UART_SAMPLE_FRAMER_CHECKSUM_EN
                    csum_d     = csum_q ^ cur_byte;
`endif
                end
            end
            WAIT_BUSY: wait_cnt_d = wait_cnt_q + 2'd1;
            WAIT_IDLE: begin
                if (!tx_busy) begin
                    if (last_byte) begin
                        toggle_d = ~toggle_q;
                    end else if (pos_q == 3'd4) begin
                        pos_d = '0;
                        ch_d  = ch_q + 3'd1;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule
